alu_sequencer: RTL and testbench

Front-end controller for the `TotalALU` datapath: accepts one operation at a time over a valid/ready request channel, drives the ALU's `dataA`/`dataB`/`Signal` inputs, and returns results over a valid/ready response channel. Single-cycle ops (AND/OR/ADD/SUB/SLT/SRL) complete in one cycle. DIVU is held for a fixed divide window, then the block automatically issues MFHI and MFLO and returns two responses, HI then LO. It sits between the issue logic and the ALU, so requesters never handle divide timing or Hi-Lo readout.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_div_timer.sv | 38 +++
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, sequencer states and opcode classification for alu_sequencer
package alu_seq_pkg;

    localparam logic [5:0] OP_AND  = 6'd36;
    localparam logic [5:0] OP_OR   = 6'd37;
    localparam logic [5:0] OP_ADD  = 6'd32;
    localparam logic [5:0] OP_SUB  = 6'd34;
    localparam logic [5:0] OP_SLT  = 6'd42;
    localparam logic [5:0] OP_SRL  = 6'd2;
    localparam logic [5:0] OP_DIVU = 6'd27;
    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_MFHI,
        ST_MFLO,
        ST_RSP_HI,
        ST_RSP
    } seq_state_t;

    // Opcodes whose ALU result is ready one cycle after issue
    function automatic logic is_single_cycle(input logic [5:0] op);
        logic r;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_div_timer.sv
// rtl/alu_seq_div_timer.sv - divide-window counter: load to zero, count up, flag DIV_WAIT-1
module alu_seq_div_timer #(
    parameter int DIV_WAIT = 35
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = $clog2(DIV_WAIT) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load has priority; the owner stops enabling once done, so the count never wraps
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == CW'(DIV_WAIT - 1));

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response front end that sequences ops and DIVU Hi/Lo readout on TotalALU
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DIV_WAIT = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_signal,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_hi,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        alu_reset,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic [5:0]  alu_signal,
    input  logic [31:0] alu_out
);

    seq_state_t  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_hi_q, rsp_hi_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_sig_q, alu_sig_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        tmr_load;
    logic        tmr_en;
    logic        tmr_done;

    alu_seq_div_timer #(
        .DIV_WAIT (DIV_WAIT)
    ) u_div_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );

    // Next-state and registered-output decode; everything holds unless a state moves it
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sig_d   = alu_sig_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    if (is_single_cycle(req_signal)) begin
                        alu_sig_d = req_signal;
                        state_d   = ST_EXEC;
                    end else if (req_signal == OP_DIVU) begin
                        alu_sig_d = OP_DIVU;
                        tmr_load  = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        // Unsupported opcode: answer at once, ALU control left at its idle AND
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_hi_d    = 1'b0;
                        rsp_data_d  = '0;
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_hi_d    = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = ST_RSP;
            end
            ST_DIV: begin
                if (tmr_done) begin
                    alu_sig_d = OP_MFHI;
                    state_d   = ST_MFHI;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_MFHI: begin
                hi_d      = alu_out;
                alu_sig_d = OP_MFLO;
                state_d   = ST_MFLO;
            end
            ST_MFLO: begin
                lo_d        = alu_out;
                rsp_data_d  = hi_q;
                rsp_valid_d = 1'b1;
                rsp_hi_d    = 1'b1;
                rsp_last_d  = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = ST_RSP_HI;
            end
            ST_RSP_HI: begin
                if (rsp_ready) begin
                    rsp_data_d = lo_q;
                    rsp_hi_d   = 1'b0;
                    rsp_last_d = 1'b1;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_hi_d    = 1'b0;
                    rsp_last_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    alu_sig_d   = OP_AND;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hi_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sig_q   <= OP_AND;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sig_q   <= alu_sig_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;
    assign alu_dataA  = alu_a_q;
    assign alu_dataB  = alu_b_q;
    assign alu_signal = alu_sig_q;
    assign alu_reset  = ~reset;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a TotalALU stand-in
module tb_alu_sequencer;

    localparam int DIV_WAIT = 35;
    localparam int DIV_LAT  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_signal = 6'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_hi;
    logic        rsp_last;
    logic        rsp_err;
    logic        alu_reset;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [5:0]  alu_signal;
    logic [31:0] alu_out;

    int n_chk  = 0;
    int n_fail = 0;

    alu_sequencer #(.DIV_WAIT(DIV_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signal (req_signal),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hi     (rsp_hi),
        .rsp_last   (rsp_last),
        .rsp_err    (rsp_err),
        .alu_reset  (alu_reset),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_signal (alu_signal),
        .alu_out    (alu_out)
    );

    always #5 clk = ~clk;

    // TotalALU stand-in: divide result lands in Hi/Lo after DIV_LAT cycles of Signal=27
    int          div_cnt;
    logic [31:0] alu_hi, alu_lo;
    always @(posedge clk or posedge alu_reset) begin
        if (alu_reset) begin
            div_cnt <= 0;
            alu_hi  <= '0;
            alu_lo  <= '0;
        end else if (alu_signal == 6'd27) begin
            div_cnt <= div_cnt + 1;
            if (div_cnt == DIV_LAT - 1 && alu_dataB != 0) begin
                alu_hi <= alu_dataA % alu_dataB;
                alu_lo <= alu_dataA / alu_dataB;
            end
        end else begin
            div_cnt <= 0;
        end
    end

    always @* begin
        case (alu_signal)
            6'd36:   alu_out = alu_dataA & alu_dataB;
            6'd37:   alu_out = alu_dataA | alu_dataB;
            6'd32:   alu_out = alu_dataA + alu_dataB;
            6'd34:   alu_out = alu_dataA - alu_dataB;
            6'd42:   alu_out = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            6'd2:    alu_out = alu_dataA >> alu_dataB[4:0];
            6'd16:   alu_out = alu_hi;
            6'd18:   alu_out = alu_lo;
            default: alu_out = 32'd0;
        endcase
    end

    // Reference result of a single-cycle request, from the opcode table
    function automatic logic [31:0] ref_res(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        case (sig)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd2:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold off the current response for 'stall' cycles, then accept it
    task automatic take_rsp(input int stall, input logic [31:0] exp);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, exp);
            chk("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b, input int stall);
        bit          is_div;
        bit          is_err;
        int          n27;
        logic [31:0] exp_v;
        logic [31:0] exp_hi;
        is_div = (sig == 6'd27);
        is_err = !(sig inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd27});
        exp_v  = is_div ? a / b : ref_res(sig, a, b);
        exp_hi = is_div ? a % b : 32'd0;
        chk("idle_req_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_signal = sig;
        req_a      = a;
        req_b      = b;
        rsp_ready  = (stall == 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_req_ready", req_ready, 0);
        if (is_err) begin
            chk("err_valid", rsp_valid, 1);
            chk("err_flag", rsp_err, 1);
            chk("err_data", rsp_data, 0);
            chk("err_last", rsp_last, 1);
            chk("err_signal", alu_signal, 36);
            take_rsp(stall, 32'd0);
        end else if (!is_div) begin
            chk("op_signal", alu_signal, sig);
            chk("op_dataA", alu_dataA, a);
            chk("op_dataB", alu_dataB, b);
            chk("op_early_valid", rsp_valid, 0);
            @(negedge clk);
            chk("op_valid", rsp_valid, 1);
            chk("op_data", rsp_data, exp_v);
            chk("op_last", rsp_last, 1);
            chk("op_err", rsp_err, 0);
            chk("op_hi", rsp_hi, 0);
            take_rsp(stall, exp_v);
        end else begin
            chk("div_dataA", alu_dataA, a);
            n27 = 0;
            while (alu_signal === 6'd27 && n27 < 100) begin
                n27++;
                @(negedge clk);
            end
            chk("div_window", n27, DIV_WAIT);
            chk("mfhi_signal", alu_signal, 16);
            @(negedge clk);
            chk("mflo_signal", alu_signal, 18);
            chk("div_early_valid", rsp_valid, 0);
            @(negedge clk);
            chk("hi_valid", rsp_valid, 1);
            chk("hi_data", rsp_data, exp_hi);
            chk("hi_flag", rsp_hi, 1);
            chk("hi_last", rsp_last, 0);
            take_rsp(stall, exp_hi);
            chk("lo_valid", rsp_valid, 1);
            chk("lo_data", rsp_data, exp_v);
            chk("lo_flag", rsp_hi, 0);
            chk("lo_last", rsp_last, 1);
            take_rsp(0, exp_v);
        end
        chk("done_valid", rsp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_signal", alu_signal, 36);
        chk("done_dataA", alu_dataA, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hi", rsp_hi, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_dataA", alu_dataA, 0);
        chk("rst_dataB", alu_dataB, 0);
        chk("rst_signal", alu_signal, 36);
        chk("rst_alu_reset", alu_reset, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops [8];
        logic [5:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd27, 6'd10};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;
        @(negedge clk);
        chk("run_alu_reset", alu_reset, 0);

        do_op(6'd32, 32'd5, 32'd7, 0);
        do_op(6'd34, 32'd3, 32'd5, 0);
        do_op(6'd42, 32'd3, 32'd5, 1);
        do_op(6'd2, 32'h80, 32'd4, 0);
        do_op(6'd27, 32'd100, 32'd7, 5);
        do_op(6'd10, 32'd9, 32'd9, 2);

        for (int i = 0; i < 20; i++) begin
            sig = ops[$urandom_range(7, 0)];
            if (sig == 6'd10) sig = 6'($urandom_range(63, 0));
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b & 32'hff;
            if (b == 0) b = 32'd1;
            do_op(sig, a, b, $urandom_range(3, 0));
        end

        req_valid  = 1'b1;
        req_signal = 6'd27;
        req_a      = 32'd100;
        req_b      = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_div_signal", alu_signal, 27);
        reset = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        chk("rst_hold_valid", rsp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        do_op(6'd32, 32'd1, 32'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
